// File: rtl/spi_resp_scheduler_pkg.sv
// Shared types and helpers for the SPI response scheduler.
package spi_sched_pkg;

    typedef enum logic {IDLE, SEND} sched_state_t;

    function automatic int num_chunks(input int nbits, input int spi_nbits);
        return (nbits + spi_nbits - 1) / spi_nbits;
    endfunction

endpackage

// File: rtl/spi_resp_scheduler_if.sv
// Requester-side and SPI-side channels of the response scheduler.
// Valid/ready: a transfer happens on a rising clk edge where both val and rdy are high;
// the data must be stable whenever val is high and rdy is low.
interface spi_resp_scheduler_if #(
    parameter int nbits      = 32,
    parameter int spi_nbits  = 16,
    parameter int num_inputs = 4,
    parameter int addr_nbits = $clog2(num_inputs)
);
    logic [num_inputs-1:0]            req_val;
    logic [num_inputs-1:0]            req_rdy;
    logic [num_inputs*nbits-1:0]      req_msg;
    logic                             resp_val;
    logic                             resp_rdy;
    logic [addr_nbits+spi_nbits-1:0]  resp_msg;
    logic                             busy;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg, busy
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg, busy
    );
endinterface

// File: rtl/spi_resp_scheduler_rr_priority_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module rr_priority_arbiter #(
    parameter int num_inputs = 4,
    parameter int addr_nbits = $clog2(num_inputs)
) (
    input  logic [num_inputs-1:0] req,
    input  logic [addr_nbits-1:0] rr_ptr,
    output logic [num_inputs-1:0] grant_oh,
    output logic [addr_nbits-1:0] grant_idx,
    output logic                  any_req
);
    logic [2*num_inputs-1:0] req_rot;
    int                      sel;
    int                      sum;

    // Rotating a doubled vector puts rr_ptr at bit 0, so the lowest set bit is the winner.
    always_comb begin
        req_rot = {req, req} >> rr_ptr;
        any_req = |req;
        sel     = 0;
        for (int j = num_inputs - 1; j >= 0; j--) begin
            if (req_rot[j]) sel = j;
        end
        sum = int'(rr_ptr) + sel;
        if (sum >= num_inputs) sum = sum - num_inputs;
        grant_idx = addr_nbits'(sum);
        grant_oh  = '0;
        for (int i = 0; i < num_inputs; i++) begin
            grant_oh[i] = any_req && (sum == i);
        end
    end
endmodule

// File: rtl/spi_resp_scheduler.sv
// Buffers one requester response at a time and streams it out as tagged SPI chunks.
module spi_resp_scheduler
    import spi_sched_pkg::*;
#(
    parameter int nbits      = 32,
    parameter int spi_nbits  = 16,
    parameter int num_inputs = 4,
    parameter int addr_nbits = $clog2(num_inputs)
) (
    input  logic              clk,
    input  logic              reset,
    spi_resp_scheduler_if.slave bus,
    output sched_state_t      state_dbg
);
    localparam int nchunks   = num_chunks(nbits, spi_nbits);
    localparam int cnt_nbits = $clog2(nchunks) + 1;
    localparam int pad_nbits = nchunks * spi_nbits;
    localparam logic [cnt_nbits-1:0] last_cnt = cnt_nbits'(nchunks - 1);

    sched_state_t          state;
    logic [addr_nbits-1:0] rr_ptr;
    logic [addr_nbits-1:0] src;
    logic [cnt_nbits-1:0]  cnt;
    logic [nbits-1:0]      msg_buf;
    logic                  post_reset;
    logic                  resp_val_r;
    logic                  busy_r;

    logic [num_inputs-1:0] grant_oh;
    logic [addr_nbits-1:0] grant_idx;
    logic                  any_req;
    logic                  fire;
    logic [nbits-1:0]      sel_msg;
    logic [pad_nbits-1:0]  padded;
    logic [spi_nbits-1:0]  chunk;

    rr_priority_arbiter #(
        .num_inputs (num_inputs),
        .addr_nbits (addr_nbits)
    ) u_arb (
        .req       (bus.req_val),
        .rr_ptr    (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Grants are withheld in the cycle after reset so the bus settles before any handshake.
    assign fire = (state == IDLE) && !post_reset && !reset && any_req;

    always_comb begin
        sel_msg = '0;
        for (int i = 0; i < num_inputs; i++) begin
            if (grant_oh[i]) sel_msg = bus.req_msg[i*nbits +: nbits];
        end
    end

    always_comb begin
        padded = pad_nbits'(msg_buf);
        chunk  = '0;
        for (int k = 0; k < nchunks; k++) begin
            if (cnt == cnt_nbits'(k)) chunk = padded[(nchunks-1-k)*spi_nbits +: spi_nbits];
        end
    end

    assign bus.req_rdy  = fire ? grant_oh : '0;
    assign bus.resp_val = resp_val_r && !reset;
    assign bus.busy     = busy_r && !reset;
    assign bus.resp_msg = {src, chunk};
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            src        <= '0;
            cnt        <= '0;
            msg_buf    <= '0;
            post_reset <= 1'b1;
            resp_val_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            post_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        msg_buf    <= sel_msg;
                        src        <= grant_idx;
                        cnt        <= '0;
                        rr_ptr     <= (grant_idx == addr_nbits'(num_inputs - 1)) ? '0
                                                                                 : grant_idx + addr_nbits'(1);
                        state      <= SEND;
                        resp_val_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.resp_rdy) begin
                        if (cnt == last_cnt) begin
                            state      <= IDLE;
                            resp_val_r <= 1'b0;
                            busy_r     <= 1'b0;
                        end else begin
                            cnt <= cnt + cnt_nbits'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_resp_scheduler.sv
// Bench for spi_resp_scheduler: directed scenarios plus random traffic against a chunk-queue model.
module tb_spi_resp_scheduler;
  import spi_sched_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int NB  = 32;
  localparam int SB  = 16;
  localparam int NC  = 2;
  localparam int NB6 = 20;
  localparam int SB6 = 8;

  // clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_resp_scheduler_if #(.nbits(NB), .spi_nbits(SB), .num_inputs(N), .addr_nbits(AW)) a_if ();
  spi_resp_scheduler_if #(.nbits(NB6), .spi_nbits(SB6), .num_inputs(N), .addr_nbits(AW)) b_if ();
  sched_state_t a_state;
  sched_state_t b_state;

  spi_resp_scheduler #(.nbits(NB), .spi_nbits(SB), .num_inputs(N), .addr_nbits(AW)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (a_if.slave),
    .state_dbg (a_state)
  );

  spi_resp_scheduler #(.nbits(NB6), .spi_nbits(SB6), .num_inputs(N), .addr_nbits(AW)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (b_if.slave),
    .state_dbg (b_state)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: outstanding tagged chunks, pointer and grant log
  logic [AW+SB-1:0] exp_q[$];
  int obs_grants[$];
  int ptr = 0;
  bit blk = 1'b1;

  always @(negedge clk) begin
    logic [N-1:0]  exp_rdy;
    logic [NB-1:0] msg;
    int g;
    if (reset) begin
      check("rst_rdy", 64'(a_if.req_rdy), 64'(0));
      check("rst_val", 64'(a_if.resp_val), 64'(0));
      check("rst_busy", 64'(a_if.busy), 64'(0));
      exp_q.delete();
      ptr = 0;
      blk = 1'b1;
    end else if (exp_q.size() > 0) begin
      check("send_rdy", 64'(a_if.req_rdy), 64'(0));
      check("send_val", 64'(a_if.resp_val), 64'(1));
      check("send_busy", 64'(a_if.busy), 64'(1));
      check("send_msg", 64'(a_if.resp_msg), 64'(exp_q[0]));
      if (a_if.resp_rdy) void'(exp_q.pop_front());
    end else begin
      g = -1;
      if (!blk) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (ptr + k) % N;
          if (g < 0 && a_if.req_val[i]) g = i;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("idle_rdy", 64'(a_if.req_rdy), 64'(exp_rdy));
      check("idle_val", 64'(a_if.resp_val), 64'(0));
      check("idle_busy", 64'(a_if.busy), 64'(0));
      for (int i = 0; i < N; i++) begin
        if (a_if.req_rdy[i]) obs_grants.push_back(i);
      end
      if (g >= 0) begin
        msg = a_if.req_msg[g*NB +: NB];
        for (int c = NC - 1; c >= 0; c--) exp_q.push_back({AW'(g), SB'(msg >> (c * SB))});
        ptr = (g + 1) % N;
      end
      blk = 1'b0;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int idx, input logic [NB-1:0] m);
    a_if.req_msg[idx*NB +: NB] = m;
  endtask

  logic [7:0] c6[3];

  initial begin
    a_if.req_val = '0;
    a_if.req_msg = '0;
    a_if.resp_rdy = 1'b1;
    b_if.req_val = '0;
    b_if.req_msg = '0;
    b_if.resp_rdy = 1'b1;
    reset = 1'b1;
    step(2);

    // lone requester 2
    reset = 1'b0;
    set_msg(2, 32'hDEADBEEF);
    a_if.req_val = 4'b0100;
    step(2);
    a_if.req_val = '0;
    step(4);

    // all requesters valid from reset: grant order 0,1,2,3,0
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_msg(i, $urandom());
    a_if.req_val = 4'b1111;
    step(2);
    obs_grants.delete();
    reset = 1'b0;
    step(17);
    a_if.req_val = '0;
    check("fair_n", 64'(obs_grants.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < obs_grants.size(); k++) check("fair_order", 64'(obs_grants[k]), 64'(k % N));
    step(4);

    // backpressure during SEND
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_msg(1, 32'h12345678);
    a_if.resp_rdy = 1'b0;
    a_if.req_val = 4'b0010;
    step(2);
    a_if.req_val = '0;
    step(3);
    a_if.resp_rdy = 1'b1;
    step(4);

    // requester 0 arrives while 3 is mid-packet
    set_msg(3, $urandom());
    set_msg(0, $urandom());
    a_if.req_val = 4'b1000;
    step(1);
    a_if.req_val = 4'b1001;
    step(4);
    a_if.req_val = '0;
    step(4);

    // reset after first chunk; next grant searches from 0
    set_msg(1, $urandom());
    a_if.req_val = 4'b0010;
    step(1);
    a_if.req_val = '0;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    obs_grants.delete();
    a_if.req_val = 4'b1010;
    step(2);
    a_if.req_val = '0;
    check("rst_regrant", 64'(obs_grants.size() > 0 ? obs_grants[0] : -1), 64'(1));
    step(4);

    // random traffic with occasional reset
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 59) == 0);
      a_if.req_val = N'($urandom());
      for (int i = 0; i < N; i++) set_msg(i, $urandom());
      a_if.resp_rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    reset = 1'b0;
    a_if.req_val = '0;
    a_if.resp_rdy = 1'b1;
    step(6);

    // narrow instance: 20-bit message in three 8-bit chunks
    c6[0] = 8'h0A;
    c6[1] = 8'hBC;
    c6[2] = 8'hDE;
    b_if.req_msg[3*NB6 +: NB6] = 20'hABCDE;
    b_if.req_val = 4'b1000;
    @(negedge clk);
    check("b_rdy", 64'(b_if.req_rdy), 64'(4'b1000));
    step(1);
    b_if.req_val = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b_val", 64'(b_if.resp_val), 64'(1));
      check("b_msg", 64'(b_if.resp_msg), 64'({2'd3, c6[k]}));
      step(1);
    end
    @(negedge clk);
    check("b_done_val", 64'(b_if.resp_val), 64'(0));
    check("b_done_busy", 64'(b_if.busy), 64'(0));
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
